// File: rtl/mem_dump_tx_pkg.sv
// Shared constants and small helpers for the BRAM-to-UART memory dump block.
package mem_dump_tx_pkg;

    // Default byte-address width of the program/data BRAM.
    localparam int DEF_ADDR_WIDTH = 10;

    // Default width of the word-count input (max count 2^LEN_WIDTH-1).
    localparam int DEF_LEN_WIDTH = 9;

    // Two-byte frame terminator. The loader's completion check uses the same value.
    localparam logic [15:0] DUMP_TRAILER = 16'hFFFF;

    // Byte stride between consecutive 16-bit words in the byte-addressed BRAM.
    localparam int WORD_BYTES = 2;

    typedef logic [7:0] byte_t;

    // Upper byte of a word. Words always go out on the wire high byte first.
    function automatic byte_t hi_byte(input logic [15:0] word);
        return word[15:8];
    endfunction

    // Lower byte of a word.
    function automatic byte_t lo_byte(input logic [15:0] word);
        return word[7:0];
    endfunction

endpackage

// File: rtl/mem_dump_tx_if.sv
// Bundle of signals between the dump block and its environment:
// control, BRAM read port and UART transmit port.
interface mem_dump_tx_if
    import mem_dump_tx_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
);

    // Control
    logic                  start;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [LEN_WIDTH-1:0]  len_words;
    logic                  busy;
    logic                  done;

    // BRAM read port
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_own;
    logic [15:0]           mem_rd_data;

    // UART transmit port
    logic                  tx_ready;
    byte_t                 tx_data;
    logic                  tx_en;

    // The dump block itself.
    modport master (
        input  start, start_addr, len_words, mem_rd_data, tx_ready,
        output busy, done, mem_addr, mem_own, tx_data, tx_en
    );

    // The board top / host side driving the dump block.
    modport slave (
        output start, start_addr, len_words, mem_rd_data, tx_ready,
        input  busy, done, mem_addr, mem_own, tx_data, tx_en
    );

endinterface

// File: rtl/mem_dump_tx_byte_sender.sv
// Single-byte UART strobe generator shared by the header, data and trailer
// states. Waits for an idle transmitter, registers the byte and pulses tx_en
// once, then blocks itself long enough that a stale tx_ready cannot cause a
// second strobe for the same request.
module uart_byte_sender
    import mem_dump_tx_pkg::*;
(
    input  logic  sys_clk,
    input  logic  rst_n,
    input  logic  req,
    input  byte_t data,
    input  logic  tx_ready,
    output byte_t tx_data,
    output logic  tx_en,
    output logic  ack
);

    // Guard stays high for the strobe cycle and the cycle after it: the
    // transmitter only drops tx_ready once it has registered tx_en.
    logic guard_q;
    logic guard;

    assign guard = tx_en | guard_q;

    // Accept the request as soon as the transmitter is idle and not guarded;
    // the caller advances its state on this same edge.
    assign ack = req & tx_ready & ~guard;

    // Strobe, data and guard registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data <= '0;
            tx_en   <= 1'b0;
            guard_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // pre-edge values; blocking ones would make guard_q see the new
            // tx_en and shift the guard window by one cycle.
            tx_en   <= ack;
            guard_q <= tx_en;
            if (ack) begin
                tx_data <= data;
            end
        end
    end

endmodule

// File: rtl/mem_dump_tx.sv
// Dumps a block of 16-bit BRAM words over UART as
//   len_hi, len_lo, {word_hi, word_lo}*len, FF, FF
// Owns the BRAM address port only while data words are being fetched/sent.
module mem_dump_tx
    import mem_dump_tx_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input logic           sys_clk,
    input logic           rst_n,
    mem_dump_tx_if.master bus
);

    typedef enum logic [3:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        RD_ADDR,
        RD_WAIT,
        DAT_HI,
        DAT_LO,
        TRL_HI,
        TRL_LO,
        FIN
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [ADDR_WIDTH-1:0] addr;      // byte address of the current word
    logic [LEN_WIDTH-1:0]  cnt;       // words still to send
    logic [15:0]           word;      // word fetched from BRAM
    logic [15:0]           len_hdr;   // zero-extended count for the header

    logic                  accept;
    logic                  last_word;
    logic                  own;

    logic                  send_req;
    byte_t                 send_byte;
    logic                  send_ack;

    // A start is honoured only in IDLE; elsewhere it is ignored.
    assign accept    = (state == IDLE) && bus.start;

    // cnt is only decremented when DAT_LO finishes, so the header still sees
    // the full requested length.
    assign len_hdr   = 16'(cnt);
    assign last_word = (cnt == LEN_WIDTH'(1));

    // State register; an async reset abandons any frame in progress.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the byte offered to the UART sender in each state.
    always_comb begin
        // NOTE: every variable gets a default first so that no path through
        // the case leaves one unassigned, which would infer a latch.
        state_next = state;
        send_req   = 1'b0;
        send_byte  = '0;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = HDR_HI;
                end
            end

            HDR_HI: begin
                send_req  = 1'b1;
                send_byte = hi_byte(len_hdr);
                if (send_ack) begin
                    state_next = HDR_LO;
                end
            end

            HDR_LO: begin
                send_req  = 1'b1;
                send_byte = lo_byte(len_hdr);
                if (send_ack) begin
                    state_next = (cnt != '0) ? RD_ADDR : TRL_HI;
                end
            end

            RD_ADDR: begin
                state_next = RD_WAIT;
            end

            RD_WAIT: begin
                state_next = DAT_HI;
            end

            DAT_HI: begin
                send_req  = 1'b1;
                send_byte = hi_byte(word);
                if (send_ack) begin
                    state_next = DAT_LO;
                end
            end

            DAT_LO: begin
                send_req  = 1'b1;
                send_byte = lo_byte(word);
                if (send_ack) begin
                    state_next = last_word ? TRL_HI : RD_ADDR;
                end
            end

            TRL_HI: begin
                send_req  = 1'b1;
                send_byte = hi_byte(DUMP_TRAILER);
                if (send_ack) begin
                    state_next = TRL_LO;
                end
            end

            TRL_LO: begin
                send_req  = 1'b1;
                send_byte = lo_byte(DUMP_TRAILER);
                if (send_ack) begin
                    state_next = FIN;
                end
            end

            FIN: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Address, word count and fetched word. The address wraps naturally at
    // 2^ADDR_WIDTH; bit 0 of the start address is dropped to keep alignment.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
            cnt  <= '0;
            word <= '0;
        end else begin
            if (accept) begin
                addr <= {bus.start_addr[ADDR_WIDTH-1:1], 1'b0};
                cnt  <= bus.len_words;
            end
            // BRAM data is valid the cycle after the address was presented.
            if (state == RD_WAIT) begin
                word <= bus.mem_rd_data;
            end
            if ((state == DAT_LO) && send_ack) begin
                addr <= addr + ADDR_WIDTH'(WORD_BYTES);
                cnt  <= cnt - LEN_WIDTH'(1);
            end
        end
    end

    // The memory port is claimed from the first fetch to the last data byte;
    // the address is parked at zero whenever the port is released.
    assign own          = (state == RD_ADDR) || (state == RD_WAIT) ||
                          (state == DAT_HI)  || (state == DAT_LO);
    assign bus.mem_own  = own;
    assign bus.mem_addr = own ? addr : '0;

    assign bus.busy     = (state != IDLE) && (state != FIN);
    assign bus.done     = (state == FIN);

    uart_byte_sender u_sender (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .req      (send_req),
        .data     (send_byte),
        .tx_ready (bus.tx_ready),
        .tx_data  (bus.tx_data),
        .tx_en    (bus.tx_en),
        .ack      (send_ack)
    );

endmodule

// File: tb/tb_mem_dump_tx.sv
// Self-checking bench for mem_dump_tx: a BRAM model with one-cycle read
// latency, a UART model that drops tx_ready for a programmable time after
// each strobe, and a frame reference model built from the frame format.
module tb_mem_dump_tx;
    import mem_dump_tx_pkg::*;

    localparam int AW = 10;
    localparam int LW = 9;
    localparam int MEM_WORDS = 1 << (AW - 1);

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;

    always #5 sys_clk = ~sys_clk;

    mem_dump_tx_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    mem_dump_tx #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Environment state shared between the monitor and the directed steps.
    logic [15:0]   mem [MEM_WORDS];
    logic [7:0]    bytes_q [$];
    int            addrs_q [$];
    int            done_cnt;
    int            own_rise;
    int            own_at_done;
    int            strobe_viol;
    int            hold;
    int            hold_cnt;
    logic          prev_en;
    logic          prev_own;
    logic [AW-1:0] prev_maddr;
    logic [AW-1:0] rd_addr_d;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // BRAM, UART and activity monitor, evaluated mid-cycle.
    initial begin
        bus.tx_ready    = 1'b1;
        bus.mem_rd_data = '0;
        rd_addr_d       = '0;
        prev_en         = 1'b0;
        prev_own        = 1'b0;
        prev_maddr      = '0;
        hold            = 0;
        hold_cnt        = 0;
        forever begin
            @(negedge sys_clk);
            // One-cycle read latency: data for the address seen last cycle.
            bus.mem_rd_data = mem[rd_addr_d[AW-1:1]];
            rd_addr_d       = bus.mem_addr;

            if (bus.tx_en === 1'b1) begin
                bytes_q.push_back(bus.tx_data);
                if (!bus.tx_ready || prev_en) strobe_viol++;
                if (hold > 0) begin
                    bus.tx_ready = 1'b0;
                    hold_cnt     = hold;
                end
            end else if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) bus.tx_ready = 1'b1;
            end
            prev_en = bus.tx_en;

            if (bus.mem_own === 1'b1) begin
                if (!prev_own || bus.mem_addr != prev_maddr) addrs_q.push_back(int'(bus.mem_addr));
                if (!prev_own) own_rise++;
            end
            prev_own   = bus.mem_own;
            prev_maddr = bus.mem_addr;

            if (bus.done === 1'b1) begin
                done_cnt++;
                if (bus.mem_own !== 1'b0) own_at_done++;
            end
        end
    end

    task automatic clear_monitor(input int h);
        bytes_q.delete();
        addrs_q.delete();
        done_cnt     = 0;
        own_rise     = 0;
        own_at_done  = 0;
        strobe_viol  = 0;
        hold         = h;
        hold_cnt     = 0;
        bus.tx_ready = 1'b1;
    endtask

    task automatic wait_bytes(input string tag, input int n);
        int cyc = 0;
        while (bytes_q.size() < n && cyc < 20000) begin
            @(negedge sys_clk);
            cyc++;
        end
        check({tag, "_progress"}, 64'(bytes_q.size() >= n), 64'd1);
    endtask

    // Runs one dump and compares it with the frame the format dictates.
    task automatic run_frame(input string tag, input logic [AW-1:0] a, input logic [LW-1:0] n,
                             input int h, input bit second_start);
        logic [7:0]  exp_bytes [$];
        int          exp_addrs [$];
        logic [15:0] w;
        int          base;
        int          ea;
        int          cyc;
        int          budget;

        base = int'(a) & ~1;
        exp_bytes.push_back(8'(int'(n) >> 8));
        exp_bytes.push_back(8'(int'(n) & 255));
        for (int i = 0; i < int'(n); i++) begin
            ea = (base + 2 * i) % (1 << AW);
            exp_addrs.push_back(ea);
            w = mem[ea / 2];
            exp_bytes.push_back(w[15:8]);
            exp_bytes.push_back(w[7:0]);
        end
        exp_bytes.push_back(DUMP_TRAILER[15:8]);
        exp_bytes.push_back(DUMP_TRAILER[7:0]);

        clear_monitor(h);
        @(negedge sys_clk);
        bus.start      = 1'b1;
        bus.start_addr = a;
        bus.len_words  = n;
        @(negedge sys_clk);
        bus.start      = 1'b0;
        bus.start_addr = AW'($urandom);
        bus.len_words  = LW'($urandom);
        check({tag, "_busy_after_start"}, 64'(bus.busy), 64'd1);

        if (second_start) begin
            wait_bytes(tag, 3);
            bus.start      = 1'b1;
            bus.start_addr = AW'($urandom);
            bus.len_words  = LW'($urandom_range(1, 20));
            @(negedge sys_clk);
            bus.start      = 1'b0;
        end

        budget = (2 * int'(n) + 4) * (h + 6) + 200;
        cyc = 0;
        while (done_cnt == 0 && cyc < budget) begin
            @(negedge sys_clk);
            cyc++;
        end
        check({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
        repeat (3) @(negedge sys_clk);

        check({tag, "_busy_idle"}, 64'(bus.busy), 64'd0);
        check({tag, "_done_once"}, 64'(done_cnt), 64'd1);
        check({tag, "_byte_count"}, 64'(bytes_q.size()), 64'(exp_bytes.size()));
        for (int i = 0; i < exp_bytes.size() && i < bytes_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 64'(bytes_q[i]), 64'(exp_bytes[i]));
        check({tag, "_addr_count"}, 64'(addrs_q.size()), 64'(exp_addrs.size()));
        for (int i = 0; i < exp_addrs.size() && i < addrs_q.size(); i++)
            check($sformatf("%s_addr%0d", tag, i), 64'(addrs_q[i]), 64'(exp_addrs[i]));
        check({tag, "_own_windows"}, 64'(own_rise), 64'(n != 0));
        check({tag, "_own_at_done"}, 64'(own_at_done), 64'd0);
        check({tag, "_strobe_viol"}, 64'(strobe_viol), 64'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
        check({tag, "_mem_own"},  64'(bus.mem_own),  64'd0);
        check({tag, "_tx_data"},  64'(bus.tx_data),  64'd0);
        check({tag, "_tx_en"},    64'(bus.tx_en),    64'd0);
        check({tag, "_busy"},     64'(bus.busy),     64'd0);
        check({tag, "_done"},     64'(bus.done),     64'd0);
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [LW-1:0] rl;

        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.len_words  = '0;
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 16'($urandom);

        // Reset values.
        repeat (3) @(negedge sys_clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge sys_clk);

        // Basic dump: 00 02 12 34 AB CD FF FF, reads at 0x200 and 0x202.
        mem['h100] = 16'h1234;
        mem['h101] = 16'hABCD;
        run_frame("basic", AW'('h200), LW'(2), 0, 1'b0);

        // Zero length: 00 00 FF FF, memory port never claimed.
        run_frame("zero_len", AW'($urandom), LW'(0), 0, 1'b0);

        // Odd start address, wrap past the top, data equal to the trailer.
        mem['h1FF] = 16'hFFFF;
        mem['h000] = 16'h0001;
        run_frame("wrap", AW'('h3FF), LW'(2), 0, 1'b0);

        // Long backpressure after every strobe.
        run_frame("backpressure", AW'($urandom), LW'(3), 500, 1'b0);

        // A second start in the middle of a dump is ignored.
        run_frame("restart", AW'('h200), LW'(2), 3, 1'b1);

        // Randomized frames with short random backpressure.
        for (int k = 0; k < 4; k++) begin
            ra = AW'($urandom);
            rl = LW'($urandom_range(0, 12));
            run_frame($sformatf("rand%0d", k), ra, rl, int'($urandom_range(0, 4)), 1'b0);
        end

        // Largest word count.
        run_frame("max_len", AW'($urandom), LW'((1 << LW) - 1), 0, 1'b0);

        // Async reset while waiting to send the low data byte.
        clear_monitor(30);
        @(negedge sys_clk);
        bus.start      = 1'b1;
        bus.start_addr = AW'('h040);
        bus.len_words  = LW'(4);
        @(negedge sys_clk);
        bus.start      = 1'b0;
        wait_bytes("mid_reset", 3);
        repeat (5) @(negedge sys_clk);
        check("mid_reset_in_data", 64'(bus.mem_own), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
        check("post_reset_idle", 64'(bus.busy), 64'd0);
        run_frame("post_reset", AW'('h040), LW'(4), 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_dump_tx.md
Name: mem_dump_tx

Overview:
- Reads a block of 16-bit words from the program/data BRAM and sends them out over UART, high byte first. This is the reverse of the UART loader, which packs byte pairs into words and writes them to BRAM.
- Sits beside the loader in the board top. It drives the memory address mux while busy and drives uart tx_data/tx_en in place of the CPU's 0x01E write path.
- Frame on the wire: len_hi, len_lo, then word hi/lo pairs, then the FF FF trailer.

Parameters:
- ADDR_WIDTH, 10: byte address width; matches `ADDR_WIDTH.
- LEN_WIDTH, 9: width of the word-count input; max count is 2^LEN_WIDTH-1.

Ports:
- sys_clk, input, 1: system clock (27 MHz).
- rst_n, input, 1: reset; asynchronous, active-low.
- start, input, 1: one-cycle request to begin a dump; sampled only in IDLE.
- start_addr, input, ADDR_WIDTH: first byte address; bit 0 is forced to 0.
- len_words, input, LEN_WIDTH: number of 16-bit words to send.
- mem_addr, output, ADDR_WIDTH: BRAM byte address.
- mem_own, output, 1: high while the block owns the memory port; the top muxes mem_addr with it and forces mem_wr=0.
- mem_rd_data, input, 16: BRAM read data, valid one cycle after mem_addr is presented.
- tx_ready, input, 1: UART transmitter idle.
- tx_data, output, 8: byte to transmit.
- tx_en, output, 1: one-cycle transmit strobe.
- busy, output, 1: high from the accepted start until the done pulse.
- done, output, 1: one-cycle pulse after the last trailer byte has been strobed.

Behaviour:
- Reset (async, rst_n=0): state IDLE. mem_addr=0, mem_own=0, tx_data=0, tx_en=0, busy=0, done=0. Word counter and byte register cleared. A reset mid-dump abandons the frame immediately; no partial trailer is sent.
- Start accept:
  - In IDLE, start=1 latches addr={start_addr[ADDR_WIDTH-1:1],1'b0} and cnt=len_words.
  - busy=1 from the next cycle.
  - start in any other state is ignored.
- States: IDLE, HDR_HI, HDR_LO, RD_ADDR, RD_WAIT, DAT_HI, DAT_LO, TRL_HI, TRL_LO, FIN.
- Byte send (common to every *_HI/*_LO state):
  - Wait until tx_ready=1 and the guard flag is clear.
  - Then register tx_data and pulse tx_en for exactly one cycle.
  - Set the guard for the following cycle so a stale tx_ready is not re-used. The state advances on the tx_en cycle.
- Header:
  - HDR_HI sends {(16-LEN_WIDTH)'0, len}[15:8]; HDR_LO sends [7:0].
  - Next state is RD_ADDR if cnt!=0, else TRL_HI.
- Data path:
  - RD_ADDR: mem_addr=addr, mem_own=1.
  - RD_WAIT: capture mem_rd_data into the word register on the cycle after RD_ADDR. Total read latency is 1 cycle.
  - DAT_HI sends word[15:8]. DAT_LO sends word[7:0], then addr+=2 and cnt-=1.
  - After DAT_LO: go to RD_ADDR if cnt!=0, else TRL_HI.
- mem_own is high from RD_ADDR of the first word through DAT_LO of the last word. It is low during the header, the trailer and IDLE.
- Trailer: TRL_HI sends 8'hFF, TRL_LO sends 8'hFF, then FIN.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- Address wrap: addr+2 wraps modulo 2^ADDR_WIDTH (e.g. 0x3FE→0x000). No error is raised.
- Data words equal to 16'hFFFF are sent verbatim. The host uses the header count, not the trailer, to delimit data.
- tx_ready held 0 indefinitely: the block waits forever. No timeout.
- len_words=0: frame is 00 00 FF FF; mem_own never asserts.

Decomposition:
- Shared package (common.sv): ADDR_WIDTH define (already present); new constant DUMP_TRAILER=16'hFFFF, shared with the loader's completion check.
- State enum stays local to mem_dump_tx.
- One sub-module: uart_byte_sender. It takes byte/req, uses tx_ready and the guard, and produces tx_data/tx_en/ack. Header, data and trailer states all reuse it.

Test Plan:
- Basic dump: BRAM[0x200]=0x1234, [0x202]=0xABCD; start_addr=0x200, len=2; tx_ready always 1 after the guard → bytes 00 02 12 34 AB CD FF FF. done pulses once; mem_addr sequence is 0x200, 0x202.
- Zero length: len=0 → bytes 00 00 FF FF; mem_own stays 0 throughout.
- Odd address, wrap, and data equal to the trailer: start_addr=0x3FF (forced to 0x3FE), len=2, BRAM[0x3FE]=0xFFFF, [0x000]=0x0001 → 00 02 FF FF 00 01 FF FF; second read at 0x000.
- Backpressure: tx_ready low for 500 cycles after each tx_en → exactly one tx_en per byte, never two strobes within one busy period of tx_ready, and the byte order is unchanged.
- start while busy: second start pulse mid-dump → ignored; the frame is identical to the single-start case.
- Async reset: rst_n low during DAT_LO → all outputs 0 within the same cycle. After release, the block is in IDLE and a new start produces a full, correct frame.
